bcd2bin_sched: RTL

BCD2BIN_SCHED -- requirements
Module: bcd2bin_sched

---
 rtl/bcd2bin_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/bcd2bin_sched.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_sched_pkg.sv
// Shared types and defaults for the BCD-to-binary request scheduler.
package bcd2bin_sched_pkg;

  localparam int unsigned DefNumReq  = 4;
  localparam int unsigned DefTimeout = 64;

  // Scheduler FSM: grant in idle, start the converter, wait, hold the response.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Index width that stays at least one bit for a single requester.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A BCD digit is only legal in 0..9.
  function automatic logic bcd_digit_bad(input logic [3:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search begins at ptr_i and wraps at NumReq-1.
module rr_arbiter
  import bcd2bin_sched_pkg::*;
#(
  parameter int unsigned  NumReq = DefNumReq,
  localparam int unsigned IdW    = id_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    idx_o,
  output logic              any_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam int unsigned PosW = IdW + 1;

  logic [PosW-1:0] pos;

  // Walk the requesters from the pointer onward and take the first one.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      pos = {1'b0, ptr_i} + PosW'(i);
      if (pos >= PosW'(NumReq)) begin
        pos = pos - PosW'(NumReq);
      end
      if (!any_o && req_i[pos[IdW-1:0]]) begin
        any_o                 = 1'b1;
        idx_o                 = pos[IdW-1:0];
        gnt_o[pos[IdW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd2bin_sched.sv
// Shares one bcd2bin converter among NUM_REQ requesters; one conversion in flight.
module bcd2bin_sched
  import bcd2bin_sched_pkg::*;
#(
  parameter int unsigned  NUM_REQ = DefNumReq,
  parameter int unsigned  TIMEOUT = DefTimeout,
  localparam int unsigned IdW     = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_bcd,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IdW-1:0]       rsp_id,
  output logic [6:0]           rsp_bin,
  output logic                 rsp_err,
  output logic                 cv_start,
  output logic [3:0]           cv_bcd1,
  output logic [3:0]           cv_bcd0,
  input  logic                 cv_ready,
  input  logic                 cv_done_tick,
  input  logic [6:0]           cv_bin
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  // cnt_q counts WAIT cycles from 0, so TIMEOUT-1 marks the last allowed cycle.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [IdW-1:0]  IdLast  = IdW'(NUM_REQ - 1);

  state_e          state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [IdW-1:0]  id_q, id_d;
  logic [3:0]      bcd1_q, bcd1_d;
  logic [3:0]      bcd0_q, bcd0_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [6:0]      bin_q, bin_d;
  logic            err_q, err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IdW-1:0]     arb_idx;
  logic               arb_any;
  logic [7:0]         sel_bcd;
  logic               grant_en;

  rr_arbiter #(
    .NumReq(NUM_REQ)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Pick the granted requester's BCD byte out of the flat input bus.
  always_comb begin
    sel_bcd = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_bcd = req_bcd[8*i +: 8];
      end
    end
  end

  // Reset is included so no requester sees its request consumed during reset.
  assign grant_en = (state_q == StIdle) && cv_ready && arb_any && reset_n;

  // Next-state logic, data capture and the one-cycle accept pulse.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    bcd1_d    = bcd1_q;
    bcd0_d    = bcd0_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    err_d     = err_q;
    req_ready = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_en) begin
          req_ready = arb_gnt;
          id_d      = arb_idx;
          bcd1_d    = sel_bcd[7:4];
          bcd0_d    = sel_bcd[3:0];
          if (bcd_digit_bad(sel_bcd[7:4]) || bcd_digit_bad(sel_bcd[3:0])) begin
            // Illegal digits never reach the converter.
            bin_d   = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end

      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end

      StWait: begin
        // Done wins over the terminal count when both land together.
        if (cv_done_tick) begin
          bin_d   = cv_bin;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          bin_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StResp: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == IdLast) ? '0 : id_q + IdW'(1);
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      bcd1_q  <= '0;
      bcd0_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      bcd1_q  <= bcd1_d;
      bcd0_q  <= bcd0_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign cv_start  = (state_q == StIssue);
  assign cv_bcd1   = bcd1_q;
  assign cv_bcd0   = bcd0_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = id_q;
  assign rsp_bin   = bin_q;
  assign rsp_err   = err_q;

endmodule
